// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop resolve WIDTH bits LSB-first.
// Optional subtract path (A + ~B + 1) is enabled by defining SERIAL_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic [WIDTH-1:0]   b_load_d;
  logic               c_load_d;
  logic               sum_bit_d;
  logic               carry_d;

`ifdef SERIAL_SUB_EN
  // Subtraction reuses the adder: invert B and force the initial carry to 1.
  assign b_load_d = sub ? ~B : B;
  assign c_load_d = sub ? 1'b1 : cin;
`else
  assign b_load_d = B;
  assign c_load_d = cin;
`endif

  assign sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_d   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // DONE accepts a new request exactly like IDLE for back-to-back use.
          if (start) begin
            a_q     <= A;
            b_q     <= b_load_d;
            carry_q <= c_load_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= carry_d;
          res_q   <= {sum_bit_d, res_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            sum_q   <= {sum_bit_d, res_q[WIDTH-1:1]};
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed, random, abort and back-to-back cases.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    int lat;
    int bcnt;
    logic [W:0] exp;
    exp = ref_add(a, b, c, s);
    @(negedge clk);
    start = 1'b1; A = a; B = b; cin = c; sub = s;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b;
    lat = 0; bcnt = 0;
    while (!done && lat < W + 4) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, W);
    check({tag, "_busycyc"}, bcnt, W);
    check({tag, "_sum"}, Sum, exp[W-1:0]);
    check({tag, "_cout"}, Cout, exp[W]);
    @(negedge clk);
    check({tag, "_donepulse"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, sum_seen;
    logic         rc, prev_done, dbl;
    logic [W:0]   exp;
    int           dcnt, bcnt, cyc, nres;
    logic [W-1:0] qa[10];
    logic [W-1:0] qb[10];
    logic         qc[10];

    rst = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    rst = 1'b0;

    do_op("add3c05", 8'h3C, 8'h05, 1'b0, 1'b0);
    do_op("wrapff01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("ffffc1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op("rand", ra, rb, rc, 1'b0);
    end

    // Second start three cycles into RUN must be dropped.
    exp = ref_add(8'h5A, 8'h33, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; A = 8'h5A; B = 8'h33; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; bcnt = 0; sum_seen = '0;
    for (int i = 0; i < W + 4; i++) begin
      if (busy) bcnt++;
      if (done) begin dcnt++; sum_seen = Sum; end
      if (i == 2) begin start = 1'b1; A = 8'h01; B = 8'h02; cin = 1'b0; end
      if (i == 3) start = 1'b0;
      @(negedge clk);
    end
    check("ign_dones", dcnt, 1);
    check("ign_busycyc", bcnt, W);
    check("ign_sum", sum_seen, exp[W-1:0]);
    check("ign_sum_held", Sum, exp[W-1:0]);

    // Reset four cycles into RUN aborts immediately with no done afterwards.
    start = 1'b1; A = 8'h77; B = 8'h11; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", Sum, 0);
    check("abort_cout", Cout, 0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    check("abort_quiet", dcnt, 0);

    // Back-to-back with start held high; operands change on each done.
    for (int i = 0; i < 10; i++) begin
      qa[i] = W'($urandom); qb[i] = W'($urandom); qc[i] = 1'($urandom);
    end
    start = 1'b1; A = qa[0]; B = qb[0]; cin = qc[0];
    cyc = 0; nres = 0; prev_done = 1'b0; dbl = 1'b0;
    while (nres < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done && prev_done) dbl = 1'b1;
      prev_done = done;
      if (done) begin
        exp = ref_add(qa[nres], qb[nres], qc[nres], 1'b0);
        check("b2b_res", {Cout, Sum}, exp);
        nres++;
        if (nres < 10) begin A = qa[nres]; B = qb[nres]; cin = qc[nres]; end
        else start = 1'b0;
      end
    end
    check("b2b_count", nres, 10);
    check("b2b_cycles", cyc, 10 * (W + 1));
    check("b2b_no_double_done", dbl, 0);
    @(negedge clk);
    check("b2b_idle", busy, 0);

`ifdef SERIAL_SUB_EN
    do_op("sub1011", 8'h10, 8'h11, 1'b0, 1'b1);
    do_op("sub2001", 8'h20, 8'h01, 1'b1, 1'b1);
    do_op("sub0add", 8'h20, 8'h01, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
